bit_serial_adder: RTL



---
 rtl/bit_serial_adder.sv | 116 +++++++++++
 1 files changed

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder evaluation per clock, LSB first, with valid/ready on both sides.
// Optional signed-overflow output enabled by defining BIT_SERIAL_ADDER_OVF_EN.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef BIT_SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_in_ready;
  logic             r_out_valid;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic             r_ovf;
`endif

  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_next;

  // Full-adder cell on the current LSB pair and the registered carry
  assign w_s        = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
  assign w_c        = (r_a_sh[0] & r_b_sh[0]) | (r_carry & (r_a_sh[0] ^ r_b_sh[0]));
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  // Shift-in at the MSB, written without a part-select so WIDTH=1 stays legal
  assign w_sum_next = (r_sum_sh >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a_sh     <= a;
            r_b_sh     <= b;
            r_carry    <= cin;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_sum_sh <= w_sum_next;
          r_carry  <= w_c;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_sum       <= w_sum_next;
            r_cout      <= w_c;
`ifdef BIT_SERIAL_ADDER_OVF_EN
            r_ovf       <= r_carry ^ w_c;
`endif
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  assign ovf       = r_ovf;
`endif

endmodule
